background_scan_reader: RTL and testbench

- Read-side companion to the dual-port background memory; drives the memory's second port (address2/chipselect2) as a read-only master.
- Scans the 80x60 RGB565 background image and upscales it by pixel replication to a 320x240 pixel stream for the LT24 LCD pixel path.
- Prefetches the next source word while the current one is being replicated, so the output stream has no bubbles when the sink is always ready.

---
 rtl/background_scan_reader_if.sv | 30 +++
 rtl/background_scan_reader.sv | 200 ++++++++++++++++++++
 tb/tb_background_scan_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/background_scan_reader_if.sv
// rtl/background_scan_reader_if.sv - memory port 2 and pixel stream bundle for background_scan_reader
interface background_scan_reader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sop;
    logic              pix_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
        input  mem_readdata,
        output pix_data, pix_valid, pix_sop, pix_eop,
        input  pix_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
        output mem_readdata,
        input  pix_data, pix_valid, pix_sop, pix_eop,
        output pix_ready
    );
endinterface

// File: rtl/background_scan_reader.sv
// rtl/background_scan_reader.sv - scans the background memory and streams it upscaled by pixel replication
module background_scan_reader #(
    parameter int SRC_W     = 80,
    parameter int SRC_H     = 60,
    parameter int SCALE     = 4,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    background_scan_reader_if.master bus
);
    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int RW = $clog2(SCALE);
    localparam logic [XW-1:0]     X_LAST    = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(SRC_H - 1);
    localparam logic [RW-1:0]     R_LAST    = RW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;

    logic [XW-1:0]     fetch_x;
    logic [RW-1:0]     fetch_pass;
    logic [YW-1:0]     fetch_y;
    logic [ADDR_W-1:0] line_base;
    logic              fetch_done;
    logic              rd_return;
    logic              cs_q;
    logic [ADDR_W-1:0] addr_q;

    logic [XW-1:0]     src_x;
    logic [YW-1:0]     src_y;
    logic [RW-1:0]     rep_x, rep_y;
    logic              cur_v, nxt_v;
    logic [DATA_W-1:0] cur_d, nxt_d;

    logic              accept, retire, last_beat, cur_v_n, nxt_v_n, issue;
    logic [XW-1:0]     fx_cur, fx_nx;
    logic [RW-1:0]     fp_cur, fp_nx;
    logic [YW-1:0]     fy_cur, fy_nx;
    logic [ADDR_W-1:0] lb_cur, lb_nx;
    logic              fdone_nx;

    always_comb begin
        accept    = cur_v & bus.pix_ready;
        retire    = accept & (rep_x == R_LAST);
        last_beat = retire & (src_x == X_LAST) & (rep_y == R_LAST) & (src_y == Y_LAST);

        // slot occupancy as it will stand after this edge
        cur_v_n = cur_v;
        nxt_v_n = nxt_v;
        if (retire) begin
            cur_v_n = nxt_v;
            nxt_v_n = 1'b0;
        end
        if (rd_return) begin
            if (!cur_v_n) cur_v_n = 1'b1;
            else          nxt_v_n = 1'b1;
        end

        // the first read of a frame is issued straight from IDLE using fresh counters
        if (state == IDLE) begin
            fx_cur = '0;
            fp_cur = '0;
            fy_cur = '0;
            lb_cur = BASE;
            issue  = start;
        end else begin
            fx_cur = fetch_x;
            fp_cur = fetch_pass;
            fy_cur = fetch_y;
            lb_cur = line_base;
            issue  = (state == SCAN) & ~fetch_done & ~cs_q & ~nxt_v_n;
        end

        fx_nx    = fx_cur + XW'(1);
        fp_nx    = fp_cur;
        fy_nx    = fy_cur;
        lb_nx    = lb_cur;
        fdone_nx = 1'b0;
        if (fx_cur == X_LAST) begin
            fx_nx = '0;
            if (fp_cur == R_LAST) begin
                fp_nx = '0;
                lb_nx = lb_cur + LINE_STEP;
                if (fy_cur == Y_LAST) fdone_nx = 1'b1;
                else                  fy_nx    = fy_cur + YW'(1);
            end else begin
                fp_nx = fp_cur + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cs_q       <= 1'b0;
            addr_q     <= BASE;
            rd_return  <= 1'b0;
            fetch_x    <= '0;
            fetch_pass <= '0;
            fetch_y    <= '0;
            line_base  <= BASE;
            fetch_done <= 1'b0;
            src_x      <= '0;
            src_y      <= '0;
            rep_x      <= '0;
            rep_y      <= '0;
            cur_v      <= 1'b0;
            nxt_v      <= 1'b0;
            cur_d      <= '0;
            nxt_d      <= '0;
        end else begin
            done      <= 1'b0;
            rd_return <= cs_q;
            cs_q      <= issue;
            if (issue) begin
                addr_q     <= lb_cur + ADDR_W'(fx_cur);
                fetch_x    <= fx_nx;
                fetch_pass <= fp_nx;
                fetch_y    <= fy_nx;
                line_base  <= lb_nx;
                fetch_done <= fdone_nx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        src_x <= '0;
                        src_y <= '0;
                        rep_x <= '0;
                        rep_y <= '0;
                        cur_v <= 1'b0;
                        nxt_v <= 1'b0;
                    end
                end
                SCAN: begin
                    if (retire) begin
                        cur_v <= nxt_v;
                        cur_d <= nxt_d;
                        nxt_v <= 1'b0;
                    end
                    if (rd_return) begin
                        if (!cur_v || (retire && !nxt_v)) begin
                            cur_v <= 1'b1;
                            cur_d <= bus.mem_readdata;
                        end else begin
                            nxt_v <= 1'b1;
                            nxt_d <= bus.mem_readdata;
                        end
                    end
                    if (accept) begin
                        if (rep_x == R_LAST) begin
                            rep_x <= '0;
                            if (src_x == X_LAST) begin
                                src_x <= '0;
                                if (rep_y == R_LAST) begin
                                    rep_y <= '0;
                                    src_y <= src_y + YW'(1);
                                end else begin
                                    rep_y <= rep_y + RW'(1);
                                end
                            end else begin
                                src_x <= src_x + XW'(1);
                            end
                        end else begin
                            rep_x <= rep_x + RW'(1);
                        end
                    end
                    if (last_beat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 2'b11;
    assign bus.pix_data       = cur_d;
    assign bus.pix_valid      = cur_v;
    assign bus.pix_sop        = cur_v & (src_x == '0) & (rep_x == '0) & (src_y == '0) & (rep_y == '0);
    assign bus.pix_eop        = cur_v & (src_x == X_LAST) & (rep_x == R_LAST) & (src_y == Y_LAST) & (rep_y == R_LAST);
endmodule

// File: tb/tb_background_scan_reader.sv
// tb/tb_background_scan_reader.sv - bench for background_scan_reader over three geometries
module tb_background_scan_reader;
    logic clk = 1'b0;
    logic reset;
    logic start0, start1, start2;
    logic busy0, busy1, busy2, done0, done1, done2;

    always #5 clk = ~clk;

    background_scan_reader_if #(.ADDR_W(13), .DATA_W(16)) if0 ();
    background_scan_reader_if #(.ADDR_W(13), .DATA_W(16)) if1 ();
    background_scan_reader_if #(.ADDR_W(13), .DATA_W(16)) if2 ();

    background_scan_reader u0 (.clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(if0));
    background_scan_reader #(.SRC_W(4), .SRC_H(2), .SCALE(2), .BASE_ADDR(100)) u1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(if1));
    background_scan_reader #(.SRC_W(8), .SRC_H(6), .SCALE(4)) u2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .bus(if2));

    // memories hold mem[a] = a; readdata is poisoned when no read was strobed
    always @(posedge clk) begin
        if0.mem_readdata <= if0.mem_chipselect ? 16'(if0.mem_address) : 16'hDEAD;
        if1.mem_readdata <= if1.mem_chipselect ? 16'(if1.mem_address) : 16'hDEAD;
        if2.mem_readdata <= if2.mem_chipselect ? 16'(if2.mem_address) : 16'hDEAD;
    end

    always @(posedge clk) begin
        #1;
        if2.pix_ready = ($urandom_range(0, 9) < 3);
    end

    logic [15:0] pd [3];
    logic [12:0] ad [3];
    logic pv [3], ps [3], pe [3], dn [3], cs [3], rdy [3], bz [3], wr [3];
    logic [1:0] be [3];
    assign pd[0] = if0.pix_data;  assign pd[1] = if1.pix_data;  assign pd[2] = if2.pix_data;
    assign ad[0] = if0.mem_address; assign ad[1] = if1.mem_address; assign ad[2] = if2.mem_address;
    assign pv[0] = if0.pix_valid; assign pv[1] = if1.pix_valid; assign pv[2] = if2.pix_valid;
    assign ps[0] = if0.pix_sop;   assign ps[1] = if1.pix_sop;   assign ps[2] = if2.pix_sop;
    assign pe[0] = if0.pix_eop;   assign pe[1] = if1.pix_eop;   assign pe[2] = if2.pix_eop;
    assign cs[0] = if0.mem_chipselect; assign cs[1] = if1.mem_chipselect; assign cs[2] = if2.mem_chipselect;
    assign rdy[0] = if0.pix_ready; assign rdy[1] = if1.pix_ready; assign rdy[2] = if2.pix_ready;
    assign wr[0] = if0.mem_write; assign wr[1] = if1.mem_write; assign wr[2] = if2.mem_write;
    assign be[0] = if0.mem_byteenable; assign be[1] = if1.mem_byteenable; assign be[2] = if2.mem_byteenable;
    assign dn[0] = done0; assign dn[1] = done1; assign dn[2] = done2;
    assign bz[0] = busy0; assign bz[1] = busy1; assign bz[2] = busy2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    function automatic int p_w(input int d);    return (d == 1) ? 4 : (d == 2) ? 8 : 80;  endfunction
    function automatic int p_h(input int d);    return (d == 1) ? 2 : (d == 2) ? 6 : 60;  endfunction
    function automatic int p_s(input int d);    return (d == 1) ? 2 : 4;                  endfunction
    function automatic int p_base(input int d); return (d == 1) ? 100 : 0;                endfunction
    function automatic int total(input int d);  return p_w(d) * p_s(d) * p_h(d) * p_s(d); endfunction

    // expected beat n: output pixel (x,y) shows source word (x/S, y/S), and mem[a] = a
    function automatic int model_pix(input int d, input int n);
        int w, x, y;
        w = p_w(d) * p_s(d);
        x = n % w;
        y = n / w;
        return (p_base(d) + (y / p_s(d)) * p_w(d) + x / p_s(d)) & 16'hFFFF;
    endfunction

    int cyc = 0;
    int n [3], reads [3], rd_frame [3], dones [3], last_cyc [3];
    bit stalled [3];
    int hold_d [3], hold_s [3], hold_e [3];
    bit nogap [3];
    int cap0 [5];
    int cap_sop, cap320, cap1280, cap_last, cap_eop;
    int cap1 [32];

    initial begin
        for (int d = 0; d < 3; d++) begin
            n[d] = 0; reads[d] = 0; rd_frame[d] = -1; dones[d] = 0; last_cyc[d] = 0; stalled[d] = 0;
        end
        nogap[0] = 1; nogap[1] = 1; nogap[2] = 0;
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                n[d] = 0;
                reads[d] = 0;
                stalled[d] = 0;
            end else begin
                if (stalled[d]) begin
                    chk("stall_valid", pv[d], 1);
                    chk("stall_data", pd[d], hold_d[d]);
                    chk("stall_sop", ps[d], hold_s[d]);
                    chk("stall_eop", pe[d], hold_e[d]);
                end
                chk("mem_write", wr[d], 0);
                if (cs[d]) reads[d]++;
                if (pv[d] && rdy[d]) begin
                    chk("pix_data", pd[d], model_pix(d, n[d]));
                    chk("pix_sop", ps[d], int'(n[d] == 0));
                    chk("pix_eop", pe[d], int'(n[d] == total(d) - 1));
                    if (d == 0) begin
                        if (n[0] < 5) cap0[n[0]] = pd[0];
                        if (n[0] == 0) cap_sop = ps[0];
                        if (n[0] == 320) cap320 = pd[0];
                        if (n[0] == 1280) cap1280 = pd[0];
                        if (n[0] == 76799) begin cap_last = pd[0]; cap_eop = pe[0]; end
                    end
                    if (d == 1 && n[1] < 32) cap1[n[1]] = pd[1];
                    last_cyc[d] = cyc;
                    n[d]++;
                end else if (nogap[d] && bz[d] && n[d] > 0) begin
                    chk("no_gap", pv[d], 1);
                end
                chk("buffered_le_2", int'(reads[d] - n[d] / p_s(d) <= 2), 1);
                if (dn[d]) begin
                    dones[d]++;
                    chk("done_timing", cyc - last_cyc[d], 1);
                    chk("done_beats", n[d], total(d));
                    rd_frame[d] = reads[d];
                    n[d] = 0;
                    reads[d] = 0;
                end
                stalled[d] = pv[d] && !rdy[d];
                hold_d[d] = pd[d];
                hold_s[d] = ps[d];
                hold_e[d] = pe[d];
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        if0.pix_ready = 1'b1;
        if1.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", bz[d], 0);
            chk("rst_done", dn[d], 0);
            chk("rst_cs", cs[d], 0);
            chk("rst_valid", pv[d], 0);
            chk("rst_sop", ps[d], 0);
            chk("rst_eop", pe[d], 0);
            chk("rst_addr", ad[d], p_base(d));
            chk("rst_data", pd[d], 0);
            chk("rst_byteenable", be[d], 3);
        end
        @(posedge clk); #1 reset = 1'b0;

        // small geometry, start held 5 cycles and re-pulsed mid-frame
        @(posedge clk); #1 start1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 start1 = 1'b0;
        t = 0;
        while (n[1] < 10 && t < 100) begin @(negedge clk); t++; end
        chk("wait_small_mid", int'(n[1] >= 10), 1);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        t = 0;
        while (dones[1] == 0 && t < 200) begin @(negedge clk); t++; end
        chk("wait_small_done", dones[1], 1);
        repeat (40) @(negedge clk);
        chk("small_one_frame", dones[1], 1);
        chk("small_no_restart", n[1], 0);
        chk("small_reads", rd_frame[1], 16);
        chk("small_b0", cap1[0], 100);
        chk("small_b1", cap1[1], 100);
        chk("small_b2", cap1[2], 101);
        chk("small_b7", cap1[7], 103);
        chk("small_b8", cap1[8], 100);
        chk("small_b16", cap1[16], 104);
        chk("small_b17", cap1[17], 104);
        chk("small_b31", cap1[31], 107);

        // random backpressure frame
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        t = 0;
        while (dones[2] == 0 && t < 20000) begin @(negedge clk); t++; end
        chk("wait_bp_done", dones[2], 1);
        chk("bp_reads", rd_frame[2], 192);

        // latency, then abandon the frame at beat 5000
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(negedge clk);
        chk("lat_cs_k1", cs[0], 1);
        chk("lat_addr_k1", ad[0], 0);
        chk("lat_busy_k1", bz[0], 1);
        @(negedge clk);
        chk("lat_valid_k2", pv[0], 0);
        @(negedge clk);
        chk("lat_valid_k3", pv[0], 1);
        chk("lat_sop_k3", ps[0], 1);
        chk("lat_data_k3", pd[0], 0);
        t = 0;
        while (n[0] < 5000 && t < 6000) begin @(negedge clk); t++; end
        chk("wait_beat5000", int'(n[0] >= 5000), 1);
        for (int i = 0; i < 4; i++) chk("lat_beat0_3", cap0[i], 0);
        chk("lat_beat4", cap0[4], 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", bz[0], 0);
        chk("abort_done", dn[0], 0);
        chk("abort_cs", cs[0], 0);
        chk("abort_valid", pv[0], 0);
        chk("abort_sop", ps[0], 0);
        chk("abort_eop", pe[0], 0);
        chk("abort_data", pd[0], 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", dones[0], 0);

        // fresh full frame with the sink always ready
        cap_sop = -1; cap320 = -1; cap1280 = -1; cap_last = -1; cap_eop = -1;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        t = 0;
        while (dones[0] == 0 && t < 80000) begin @(negedge clk); t++; end
        chk("wait_full_done", dones[0], 1);
        chk("full_sop", cap_sop, 1);
        chk("full_beat320", cap320, 16'h0000);
        chk("full_beat1280", cap1280, 16'h0050);
        chk("full_last", cap_last, 16'h12BF);
        chk("full_eop", cap_eop, 1);
        chk("full_reads", rd_frame[0], 19200);
        @(negedge clk);
        chk("full_busy_low", bz[0], 0);
        chk("full_done_once", dones[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
